// File: rtl/neuron_argmax_reader.sv
// Argmax reader for the neuron array: it captures all outputs on the done rising edge,
// scans them one per cycle, and presents the winning class on a valid/ready handshake.

module neuron_argmax_slot #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)       q <= '0;
        else if (load) q <= d;
    end
endmodule

module neuron_argmax_reader #(
    parameter int NUM_NEURONS  = 10,
    parameter int OUTPUT_WIDTH = 26,
    parameter int INDEX_WIDTH  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_NEURONS*OUTPUT_WIDTH-1:0] NEURON_OUTS,
    input  logic [NUM_NEURONS-1:0]              NEURON_DONE,
    input  logic                                ready,
    output logic [INDEX_WIDTH-1:0]              CLASS_OUT,
    output logic [OUTPUT_WIDTH-1:0]             MAX_VALUE,
    output logic                                valid,
    output logic                                busy,
    output logic                                overrun
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_NEURONS - 1);

    logic [1:0]                                   state;
    logic [INDEX_WIDTH-1:0]                       scan_idx;
    logic [OUTPUT_WIDTH-1:0]                      best_val;
    logic [INDEX_WIDTH-1:0]                       best_idx;
    logic                                         done_prev;
    logic [NUM_NEURONS-1:0][OUTPUT_WIDTH-1:0]     cap;

    logic                    all_done;
    logic                    start;
    logic                    handshake;
    logic                    cap_load;
    logic [OUTPUT_WIDTH-1:0] entry;
    logic                    take;
    logic [OUTPUT_WIDTH-1:0] next_val;
    logic [INDEX_WIDTH-1:0]  next_idx;

    assign all_done  = &NEURON_DONE;
    assign start     = all_done & ~done_prev;
    assign handshake = (state == ST_HOLD) & ready;
    // The capture array may only be refreshed when no scan depends on it.
    assign cap_load  = start & ((state == ST_IDLE) | handshake);

    genvar k;
    generate
        for (k = 0; k < NUM_NEURONS; k++) begin : g_slot
            neuron_argmax_slot #(.W(OUTPUT_WIDTH)) u_slot (
                .clk  (clk),
                .rst  (rst),
                .load (cap_load),
                .d    (NEURON_OUTS[k*OUTPUT_WIDTH +: OUTPUT_WIDTH]),
                .q    (cap[k])
            );
        end
    endgenerate

    // Strict greater-than keeps the lowest index on ties; entry 0 always seeds the best.
    always_comb begin
        entry    = cap[scan_idx];
        take     = (scan_idx == '0) || ($signed(entry) > $signed(best_val));
        next_val = best_val;
        next_idx = best_idx;
        if (take) begin
            next_val = entry;
            next_idx = scan_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            scan_idx  <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            done_prev <= 1'b0;
            CLASS_OUT <= '0;
            MAX_VALUE <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done_prev <= all_done;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SCAN;
                        scan_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    best_val <= next_val;
                    best_idx <= next_idx;
                    scan_idx <= scan_idx + INDEX_WIDTH'(1);
                    if (start) overrun <= 1'b1;
                    if (scan_idx == LAST_IDX) begin
                        state     <= ST_HOLD;
                        CLASS_OUT <= next_idx;
                        MAX_VALUE <= next_val;
                        valid     <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (start) begin
                            state    <= ST_SCAN;
                            scan_idx <= '0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (start) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_argmax_reader.sv
// Randomized bench for neuron_argmax_reader. A countdown-based reference model runs in the bench,
// and its argmax is computed by a plain loop over the captured values.
module tb_neuron_argmax_reader;
    localparam int N  = 10;
    localparam int W  = 26;
    localparam int IW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] outs = '0;
    logic [N-1:0]   done = '0;
    logic           ready = 1'b0;
    logic [IW-1:0]  CLASS_OUT;
    logic [W-1:0]   MAX_VALUE;
    logic           valid, busy, overrun;

    neuron_argmax_reader #(.NUM_NEURONS(N), .OUTPUT_WIDTH(W), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .NEURON_OUTS(outs), .NEURON_DONE(done), .ready(ready),
        .CLASS_OUT(CLASS_OUT), .MAX_VALUE(MAX_VALUE), .valid(valid), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int dut_results = 0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: state is "free", "scanning with a countdown", or "holding a result".
    logic signed [W-1:0] cap [N];
    int                  m_cnt = 0;
    bit                  m_busy = 0, m_valid = 0, m_over = 0, m_prev = 0;
    logic [IW-1:0]       m_class = '0, p_class = '0;
    logic [W-1:0]        m_max = '0, p_max = '0;

    task automatic model_capture();
        for (int k = 0; k < N; k++) cap[k] = outs[k*W +: W];
        p_class = '0;
        p_max   = cap[0];
        for (int k = 1; k < N; k++)
            if ($signed(cap[k]) > $signed(p_max)) begin
                p_max   = cap[k];
                p_class = IW'(k);
            end
        m_cnt = N;
    endtask

    always @(posedge clk) begin
        bit st;
        if (rst) begin
            m_cnt = 0; m_busy = 0; m_valid = 0; m_over = 0; m_prev = 0;
            m_class = '0; m_max = '0;
        end else begin
            st     = (&done) && !m_prev;
            m_prev = &done;
            if (!m_busy) begin
                if (st) begin
                    model_capture();
                    m_busy = 1;
                end
            end else if (m_cnt > 0) begin
                if (st) m_over = 1;
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1;
                    m_class = p_class;
                    m_max   = p_max;
                end
            end else begin
                if (ready) begin
                    m_valid = 0;
                    if (st) model_capture();
                    else    m_busy = 0;
                end else if (st) begin
                    m_over = 1;
                end
            end
        end
    end

    always @(posedge clk)
        if (!rst && valid && ready) dut_results++;

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid",     {63'd0, valid},   {63'd0, m_valid});
            check("busy",      {63'd0, busy},    {63'd0, m_busy});
            check("overrun",   {63'd0, overrun}, {63'd0, m_over});
            check("class_out", 64'(CLASS_OUT),   64'(m_class));
            check("max_value", 64'(MAX_VALUE),   64'(m_max));
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_out(int k, logic [W-1:0] v);
        outs[k*W +: W] = v;
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 26'h2000000;
            1:       return 26'h1FFFFFF;
            2:       return '0;
            3:       return 26'h3FFFFFF;
            4:       return W'($urandom_range(0, 3));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic randomize_outs();
        for (int k = 0; k < N; k++) set_out(k, rand_val());
    endtask

    // Waits for valid at successive negedges; k is the count of negedges, or -1 on timeout.
    task automatic wait_valid(output int k);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (valid) begin
                k = i;
                return;
            end
        end
        check("valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat, r0;
        rst = 1'b1; done = '0; ready = 1'b0;
        step(3);
        chk_en = 1'b1;
        check("rst_valid",   {63'd0, valid},   64'd0);
        check("rst_busy",    {63'd0, busy},    64'd0);
        check("rst_overrun", {63'd0, overrun}, 64'd0);
        check("rst_class",   64'(CLASS_OUT),   64'd0);
        check("rst_max",     64'(MAX_VALUE),   64'd0);
        rst = 1'b0;
        step(2);

        // Basic argmax
        for (int k = 0; k < N; k++) set_out(k, W'(k * 262144));
        set_out(7, 26'h0500000);
        ready = 1'b1; done = '1;
        wait_valid(lat);
        check("basic_latency", 64'(lat), 64'd11);
        check("basic_class", 64'(CLASS_OUT), 64'd7);
        check("basic_max", 64'(MAX_VALUE), 64'h0500000);
        check("model_basic_class", 64'(m_class), 64'd7);
        step(1);
        check("basic_valid_drop", {63'd0, valid}, 64'd0);
        done = '0; step(2);

        // Negative values with a tie between 2 and 5
        for (int k = 0; k < N; k++) set_out(k, 26'h3FC0000);
        set_out(2, 26'h3FF0000); set_out(5, 26'h3FF0000);
        done = '1;
        wait_valid(lat);
        check("tie_class", 64'(CLASS_OUT), 64'd2);
        check("tie_max", 64'(MAX_VALUE), 64'h3FF0000);
        check("model_tie_max", 64'(m_max), 64'h3FF0000);
        step(1); done = '0; step(2);

        // All most-negative
        for (int k = 0; k < N; k++) set_out(k, 26'h2000000);
        done = '1;
        wait_valid(lat);
        check("minneg_class", 64'(CLASS_OUT), 64'd0);
        check("minneg_max", 64'(MAX_VALUE), 64'h2000000);
        step(1); done = '0; step(2);

        // Backpressure with live inputs scrambled after capture
        ready = 1'b0;
        randomize_outs();
        done = '1;
        step(1);
        for (int k = 0; k < 40 && !valid; k++) begin
            randomize_outs();
            step(1);
        end
        check("bp_valid", {63'd0, valid}, 64'd1);
        repeat (20) begin
            randomize_outs();
            step(1);
            check("bp_hold_valid", {63'd0, valid}, 64'd1);
        end
        ready = 1'b1;
        step(1);
        check("bp_release", {63'd0, valid}, 64'd0);
        done = '0; step(2);

        // Back-to-back: new start on the handshake edge
        ready = 1'b0;
        randomize_outs();
        done = '1;
        wait_valid(lat);
        done = '0;
        step(1);
        randomize_outs();
        done = '1; ready = 1'b1;
        step(1);
        ready = 1'b0;
        check("b2b_valid_low", {63'd0, valid}, 64'd0);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_valid(lat);
        check("b2b_latency", 64'(lat + 1), 64'd11);
        check("b2b_overrun", {63'd0, overrun}, 64'd0);
        ready = 1'b1;
        step(1); done = '0; step(2);

        // Overrun: done re-rises during scan
        r0 = dut_results;
        randomize_outs();
        done = '1;
        step(3);
        done = '0;
        step(1);
        done = '1;
        step(1);
        check("ovr_flag", {63'd0, overrun}, 64'd1);
        wait_valid(lat);
        step(20);
        check("ovr_results", 64'(dut_results - r0), 64'd1);
        done = '0; step(2);

        // Reset mid-scan, done held through release
        randomize_outs();
        done = '1;
        step(5);
        rst = 1'b1;
        step(1);
        check("mrst_valid",   {63'd0, valid},   64'd0);
        check("mrst_busy",    {63'd0, busy},    64'd0);
        check("mrst_class",   64'(CLASS_OUT),   64'd0);
        check("mrst_max",     64'(MAX_VALUE),   64'd0);
        check("mrst_overrun", {63'd0, overrun}, 64'd0);
        rst = 1'b0;
        r0 = dut_results;
        step(1);
        check("mrst_restart_busy", {63'd0, busy}, 64'd1);
        // Level-only done: done stays high, exactly one result
        step(60);
        check("level_results", 64'(dut_results - r0), 64'd1);
        done = '0; step(2);

        // Random phase
        repeat (3000) begin
            step(1);
            rst   = ($urandom_range(0, 599) == 0);
            ready = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1:    done = '1;
                    2:       done = '0;
                    default: done = N'($urandom);
                endcase
            end
            if ($urandom_range(0, 3) == 0) randomize_outs();
        end
        rst = 1'b0; ready = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
